fl: RTL and testbench

- Free list of physical-register tags for the 2-wide R10K-style rename stage.
- Sits directly upstream of the map table and feeds it `fl_pr0`/`fl_pr1`, the new destination PRs for dispatch slots 0/1.
- Takes back the old mappings (Told) when the ROB retires instructions.
- Rolls speculative allocations back on ROB recovery.

---
 rtl/fl_pkg.sv | 22 ++
 rtl/fl_ptr.sv | 26 ++
 rtl/fl.sv | 108 ++++++++++
 tb/tb_fl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fl_pkg.sv
// Shared sizing and types for the rename-stage free list.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
package fl_pkg;

   localparam int PR_NUM   = 64;
   localparam int AR_NUM   = 32;
   localparam int PR_WIDTH = 7;
   localparam int FL_DEPTH = PR_NUM - AR_NUM;
   localparam int IDX_W    = $clog2(FL_DEPTH);
   localparam int PTR_W    = IDX_W + 1;
   localparam int CNT_W    = 2;

   typedef logic [PR_WIDTH-1:0] pr_tag_t;
   typedef logic [PTR_W-1:0]    fl_ptr_t;
   typedef logic [IDX_W-1:0]    fl_idx_t;
   typedef logic [CNT_W-1:0]    fl_cnt_t;

   function automatic fl_cnt_t min_cnt(input fl_cnt_t a, input fl_cnt_t b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/fl_ptr.sv
// Wrap-bit circular-buffer pointer that advances by 0/1/2 per cycle,
// with a load path used when the speculative head is rolled back.
module fl_ptr
   import fl_pkg::*;
#(
   parameter fl_ptr_t RESET_VAL = '0
) (
   input  logic    clock,
   input  logic    reset,
   input  logic    load,
   input  fl_ptr_t load_val,
   input  fl_cnt_t inc,
   output fl_ptr_t ptr
);

   always_ff @(posedge clock) begin
      if (!reset) begin
         ptr <= RESET_VAL;
      end else if (load) begin
         ptr <= load_val;
      end else begin
         ptr <= ptr + fl_ptr_t'(inc);
      end
   end

endmodule

// File: rtl/fl.sv
// Free list of physical-register tags for a 2-wide rename stage: allocates
// at head, frees retired Told values at tail, and rolls head back on recovery.
module fl
   import fl_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic [CNT_W-1:0]    rob_dispatch_num,
   input  logic [CNT_W-1:0]    rob_retire_num,
   input  logic [PR_WIDTH-1:0] rob_retire_told0,
   input  logic [PR_WIDTH-1:0] rob_retire_told1,
   input  logic                rob_recover,
   output logic [PR_WIDTH-1:0] fl_pr0,
   output logic [PR_WIDTH-1:0] fl_pr1,
   output logic [1:0]          fl_avail_num,
   output logic [5:0]          fl_free_cnt
);

   pr_tag_t buffer [FL_DEPTH];

   fl_ptr_t head;
   fl_ptr_t c_head;
   fl_ptr_t tail;
   fl_ptr_t free_cnt;
   fl_ptr_t room;
   fl_ptr_t head_load;
   fl_idx_t head_idx;
   fl_idx_t head_idx1;
   fl_idx_t tail_idx;
   fl_idx_t tail_idx1;
   fl_cnt_t avail;
   fl_cnt_t req_r;
   fl_cnt_t n_d;
   fl_cnt_t n_r;
   logic    over_retire;

   // Over-full retires are clamped to the remaining room so the pointers
   // never overrun; recovery suppresses allocation but keeps same-cycle retires.
   always_comb begin
      free_cnt    = tail - head;
      avail       = (free_cnt >= fl_ptr_t'(2)) ? fl_cnt_t'(2) : free_cnt[CNT_W-1:0];
      room        = fl_ptr_t'(FL_DEPTH) - free_cnt;
      req_r       = (rob_retire_num > fl_cnt_t'(2)) ? fl_cnt_t'(2) : rob_retire_num;
      over_retire = (fl_ptr_t'(req_r) > room);
      n_r         = over_retire ? room[CNT_W-1:0] : req_r;
      n_d         = rob_recover ? fl_cnt_t'(0) : min_cnt(rob_dispatch_num, avail);
      head_load   = c_head + fl_ptr_t'(n_r);
      head_idx    = head[IDX_W-1:0];
      head_idx1   = head_idx + fl_idx_t'(1);
      tail_idx    = tail[IDX_W-1:0];
      tail_idx1   = tail_idx + fl_idx_t'(1);
   end

   assign fl_pr0       = buffer[head_idx];
   assign fl_pr1       = buffer[head_idx1];
   assign fl_avail_num = avail;
   assign fl_free_cnt  = free_cnt;

   fl_ptr #(.RESET_VAL(fl_ptr_t'(0))) u_head (
      .clock    (clock),
      .reset    (reset),
      .load     (rob_recover),
      .load_val (head_load),
      .inc      (n_d),
      .ptr      (head)
   );

   fl_ptr #(.RESET_VAL(fl_ptr_t'(0))) u_c_head (
      .clock    (clock),
      .reset    (reset),
      .load     (1'b0),
      .load_val (fl_ptr_t'(0)),
      .inc      (n_r),
      .ptr      (c_head)
   );

   fl_ptr #(.RESET_VAL(fl_ptr_t'(FL_DEPTH))) u_tail (
      .clock    (clock),
      .reset    (reset),
      .load     (1'b0),
      .load_val (fl_ptr_t'(0)),
      .inc      (n_r),
      .ptr      (tail)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < FL_DEPTH; i++) begin
            buffer[i] <= pr_tag_t'(AR_NUM + i);
         end
      end else begin
         if (n_r != fl_cnt_t'(0)) begin
            buffer[tail_idx] <= rob_retire_told0;
         end
         if (n_r == fl_cnt_t'(2)) begin
            buffer[tail_idx1] <= rob_retire_told1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         assert (!over_retire)
            else $error("fl: retire of %0d tags overflows free list holding %0d", req_r, free_cnt);
      end
   end

endmodule

// File: tb/tb_fl.sv
// Table-driven self-checking bench for the free list; expected post-edge
// outputs travel through a scoreboard queue from stimulus to check.
module tb_fl;
   import fl_pkg::*;

   logic          clock = 1'b0;
   logic          reset;
   logic [1:0]    rob_dispatch_num;
   logic [1:0]    rob_retire_num;
   logic [6:0]    rob_retire_told0;
   logic [6:0]    rob_retire_told1;
   logic          rob_recover;
   logic [6:0]    fl_pr0;
   logic [6:0]    fl_pr1;
   logic [1:0]    fl_avail_num;
   logic [5:0]    fl_free_cnt;

   typedef struct {
      string      name;
      logic       rst_n;
      logic [1:0] disp;
      logic [1:0] ret;
      logic [6:0] t0;
      logic [6:0] t1;
      logic       rec;
      logic       chk_tags;
      logic [6:0] e_pr0;
      logic [6:0] e_pr1;
      logic [1:0] e_avail;
      logic [5:0] e_cnt;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   vec_count   = 0;
   int   miscompares = 0;

   fl dut (
      .clock            (clock),
      .reset            (reset),
      .rob_dispatch_num (rob_dispatch_num),
      .rob_retire_num   (rob_retire_num),
      .rob_retire_told0 (rob_retire_told0),
      .rob_retire_told1 (rob_retire_told1),
      .rob_recover      (rob_recover),
      .fl_pr0           (fl_pr0),
      .fl_pr1           (fl_pr1),
      .fl_avail_num     (fl_avail_num),
      .fl_free_cnt      (fl_free_cnt)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(input string name, input logic rst_n, input int d, input int r,
                               input int t0, input int t1, input logic rec, input logic chk,
                               input int p0, input int p1, input int cnt);
      vec_t v;
      v.name     = name;
      v.rst_n    = rst_n;
      v.disp     = 2'(d);
      v.ret      = 2'(r);
      v.t0       = 7'(t0);
      v.t1       = 7'(t1);
      v.rec      = rec;
      v.chk_tags = chk;
      v.e_pr0    = 7'(p0);
      v.e_pr1    = 7'(p1);
      v.e_avail  = (cnt >= 2) ? 2'd2 : 2'(cnt);
      v.e_cnt    = 6'(cnt);
      return v;
   endfunction

   task automatic checkOutput();
      vec_t e;
      if (sb.size() == 0) begin
         $display("[TB] FAIL scoreboard_empty: no expected entry for DUT output");
         miscompares++;
         return;
      end
      e = sb.pop_front();
      vec_count++;
      if (fl_free_cnt !== e.e_cnt) begin
         $display("[TB] FAIL %s fl_free_cnt: got %0d, want %0d", e.name, fl_free_cnt, e.e_cnt);
         miscompares++;
      end
      if (fl_avail_num !== e.e_avail) begin
         $display("[TB] FAIL %s fl_avail_num: got %0d, want %0d", e.name, fl_avail_num, e.e_avail);
         miscompares++;
      end
      if (e.chk_tags && (fl_pr0 !== e.e_pr0)) begin
         $display("[TB] FAIL %s fl_pr0: got %0d, want %0d", e.name, fl_pr0, e.e_pr0);
         miscompares++;
      end
      if (e.chk_tags && (fl_pr1 !== e.e_pr1)) begin
         $display("[TB] FAIL %s fl_pr1: got %0d, want %0d", e.name, fl_pr1, e.e_pr1);
         miscompares++;
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      reset            = v.rst_n;
      rob_dispatch_num = v.disp;
      rob_retire_num   = v.ret;
      rob_retire_told0 = v.t0;
      rob_retire_told1 = v.t1;
      rob_recover      = v.rec;
      sb.push_back(v);
      @(posedge clock);
      #1;
      checkOutput();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset, release, then drain all 32 tags two at a time.
      tbl.push_back(mk("reset_a", 0, 0, 0, 0, 0, 0, 1, 32, 33, 32));
      tbl.push_back(mk("reset_b", 0, 0, 0, 0, 0, 0, 1, 32, 33, 32));
      tbl.push_back(mk("release", 1, 0, 0, 0, 0, 0, 1, 32, 33, 32));
      for (int k = 0; k < 16; k++)
         tbl.push_back(mk("drain", 1, 2, 0, 0, 0, 0, k < 15, 34 + 2*k, 35 + 2*k, 30 - 2*k));
      tbl.push_back(mk("over_request", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk("retire_from_empty", 1, 2, 2, 0, 1, 0, 1, 0, 1, 2));
      tbl.push_back(mk("idle_after_retire", 1, 0, 0, 0, 0, 0, 1, 0, 1, 2));

      // Speculative allocation rolled back to the committed head.
      tbl.push_back(mk("rec_reset", 0, 0, 0, 0, 0, 0, 1, 32, 33, 32));
      tbl.push_back(mk("rec_disp_a", 1, 2, 0, 0, 0, 0, 1, 34, 35, 30));
      tbl.push_back(mk("rec_disp_b", 1, 2, 0, 0, 0, 0, 1, 36, 37, 28));
      tbl.push_back(mk("rec_retire1", 1, 0, 1, 5, 0, 0, 1, 36, 37, 29));
      tbl.push_back(mk("recover", 1, 0, 0, 0, 0, 1, 1, 33, 34, 32));
      for (int j = 1; j <= 15; j++)
         tbl.push_back(mk("post_recover", 1, 2, 0, 0, 0, 0, 1,
                          (j < 15) ? 33 + 2*j : 63, (j < 15) ? 34 + 2*j : 5, 32 - 2*j));

      // Wrap: allocate 31, free 31 Told values, then straddle index 31->0.
      tbl.push_back(mk("wrap_reset", 0, 0, 0, 0, 0, 0, 1, 32, 33, 32));
      for (int k = 0; k < 15; k++)
         tbl.push_back(mk("wrap_disp", 1, 2, 0, 0, 0, 0, 1, 34 + 2*k, 35 + 2*k, 30 - 2*k));
      tbl.push_back(mk("wrap_disp1", 1, 1, 0, 0, 0, 0, 1, 63, 32, 1));
      for (int i = 0; i < 15; i++)
         tbl.push_back(mk("wrap_retire", 1, 0, 2, 2*i, 2*i + 1, 0, 1, 63, 0, 3 + 2*i));
      tbl.push_back(mk("wrap_retire1", 1, 0, 1, 30, 0, 0, 1, 63, 0, 32));
      tbl.push_back(mk("wrap_straddle", 1, 2, 0, 0, 0, 0, 1, 1, 2, 30));
      tbl.push_back(mk("wrap_disp_more", 1, 2, 0, 0, 0, 0, 1, 3, 4, 28));
      tbl.push_back(mk("recover_with_retire", 1, 2, 2, 40, 41, 1, 1, 1, 2, 32));

      for (int n = 0; n < tbl.size(); n++)
         applyStimulus(tbl[n]);

      // Reset must win over every concurrently active input.
      applyStimulus(mk("reset_overrides", 0, 2, 2, 50, 51, 1, 1, 32, 33, 32));
      applyStimulus(mk("reset_overrides_release", 1, 0, 0, 0, 0, 0, 1, 32, 33, 32));

      if (sb.size() != 0) begin
         $display("[TB] FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
         miscompares++;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule
